regfile_dump_ctrl: RTL and testbench

- Sequencing initiator on the far side of the register file's read and write ports.
- Dump mode: reads a contiguous index range through the combinational read port and streams each word out over a valid/ready channel.
- Load mode: accepts a valid/ready word stream and issues one register write per beat.
- Used for debug snapshot/restore and for test preload of the single-cycle core's register file.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_dump_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register file dump/load controller.
package regfile_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    TX,
    WR,
    CSUM,
    DONE
  } rfd_state_e;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Register file dump/load sequencer.
// Dump: reads a wrapping index range through the combinational read port and streams each word
// out over valid/ready. Load: accepts a valid/ready stream and writes one register per beat.
// Optional feature: define REGFILE_DUMP_CSUM_EN to append/verify an XOR checksum beat.
module regfile_dump_ctrl
  import regfile_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_mode,
  input  logic [AW-1:0]   i_first_idx,
  input  logic [AW-1:0]   i_last_idx,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_csum_err,
  output logic [AW-1:0]   o_rf_raddr,
  input  logic [XLEN-1:0] i_rf_rdata,
  output logic [AW-1:0]   o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic            o_rf_wren,
  output logic [XLEN-1:0] o_tx_data,
  output logic [AW-1:0]   o_tx_idx,
  output logic            o_tx_valid,
  output logic            o_tx_last,
  input  logic            i_tx_ready,
  input  logic [XLEN-1:0] i_rx_data,
  input  logic            i_rx_valid,
  output logic            o_rx_ready
);

  rfd_state_e      state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] tx_data_q, tx_data_d;
  logic [AW-1:0]   tx_idx_q, tx_idx_d;

`ifdef REGFILE_DUMP_CSUM_EN
  logic [XLEN-1:0] csum_q, csum_d;
  logic            csum_err_q, csum_err_d;
  logic            mode_q, mode_d;

  // Checksum accumulator, sticky error flag and latched command mode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      csum_q     <= '0;
      csum_err_q <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      csum_q     <= csum_d;
      csum_err_q <= csum_err_d;
      mode_q     <= mode_d;
    end
  end

  assign o_csum_err = csum_err_q;
`else
  assign o_csum_err = 1'b0;
`endif

  // State, index/beat counters and the held tx beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_idx_q  <= tx_idx_d;
    end
  end

  // Next-state and output decode; index arithmetic wraps naturally since NREG is a power of two.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_idx_d   = tx_idx_q;
`ifdef REGFILE_DUMP_CSUM_EN
    csum_d     = csum_q;
    csum_err_d = csum_err_q;
    mode_d     = mode_q;
`endif
    o_rf_raddr = '0;
    o_rf_waddr = '0;
    o_rf_wdata = '0;
    o_rf_wren  = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_last  = 1'b0;
    o_rx_ready = 1'b0;
    o_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          idx_d   = i_first_idx;
          cnt_d   = i_last_idx - i_first_idx;
          state_d = i_mode ? WR : RD;
`ifdef REGFILE_DUMP_CSUM_EN
          csum_d     = '0;
          csum_err_d = 1'b0;
          mode_d     = i_mode;
`endif
        end
      end
      RD: begin
        o_rf_raddr = idx_q;
        tx_data_d  = i_rf_rdata;
        tx_idx_d   = idx_q;
        state_d    = TX;
`ifdef REGFILE_DUMP_CSUM_EN
        csum_d     = csum_q ^ i_rf_rdata;
`endif
      end
      TX: begin
        o_tx_valid = 1'b1;
`ifndef REGFILE_DUMP_CSUM_EN
        o_tx_last  = (cnt_q == '0);
`endif
        if (i_tx_ready) begin
          if (cnt_q == '0) begin
`ifdef REGFILE_DUMP_CSUM_EN
            state_d   = CSUM;
            tx_data_d = csum_q;
            tx_idx_d  = '0;
`else
            state_d   = DONE;
`endif
          end else begin
            idx_d   = idx_q + AW'(1);
            cnt_d   = cnt_q - AW'(1);
            state_d = RD;
          end
        end
      end
      WR: begin
        o_rx_ready = 1'b1;
        if (i_rx_valid) begin
          // x0 is hardwired: consume the beat without writing.
          o_rf_wren  = (idx_q != '0);
          o_rf_waddr = idx_q;
          o_rf_wdata = i_rx_data;
`ifdef REGFILE_DUMP_CSUM_EN
          csum_d     = csum_q ^ i_rx_data;
`endif
          if (cnt_q == '0) begin
`ifdef REGFILE_DUMP_CSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d = idx_q + AW'(1);
            cnt_d = cnt_q - AW'(1);
          end
        end
      end
      CSUM: begin
`ifdef REGFILE_DUMP_CSUM_EN
        if (!mode_q) begin
          o_tx_valid = 1'b1;
          o_tx_last  = 1'b1;
          if (i_tx_ready) state_d = DONE;
        end else begin
          o_rx_ready = 1'b1;
          if (i_rx_valid) begin
            if (i_rx_data != csum_q) csum_err_d = 1'b1;
            state_d = DONE;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy    = (state_q != IDLE);
  assign o_tx_data = tx_data_q;
  assign o_tx_idx  = tx_idx_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl: behavioural register file plus expected-contents
// model, directed and randomized dump/load scenarios. Honours REGFILE_DUMP_CSUM_EN.
module tb_regfile_dump_ctrl;
  import regfile_pkg::*;

  localparam int NR = NREG;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_start = 1'b0;
  logic            i_mode = 1'b0;
  logic [AW-1:0]   i_first_idx = '0;
  logic [AW-1:0]   i_last_idx = '0;
  logic            o_busy, o_done, o_csum_err;
  logic [AW-1:0]   o_rf_raddr, o_rf_waddr, o_tx_idx;
  logic [XLEN-1:0] i_rf_rdata, o_rf_wdata, o_tx_data;
  logic            o_rf_wren, o_tx_valid, o_tx_last, o_rx_ready;
  logic            i_tx_ready = 1'b0;
  logic [XLEN-1:0] i_rx_data = '0;
  logic            i_rx_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  // Register file as seen by the controller, plus a bench-side poke port.
  logic [XLEN-1:0] rf [NR];
  logic [XLEN-1:0] rf_exp [NR];
  logic [XLEN-1:0] ld_data [NR];
  logic            tb_we = 1'b0;
  logic [AW-1:0]   tb_waddr = '0;
  logic [XLEN-1:0] tb_wdata = '0;

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_rf_wren) rf[o_rf_waddr] <= o_rf_wdata;
    else if (tb_we) rf[tb_waddr] <= tb_wdata;
  end

  assign i_rf_rdata = rf[o_rf_raddr];

  wire [85:0] all_outs = {o_busy, o_done, o_csum_err, o_rf_raddr, o_rf_waddr, o_rf_wdata,
                          o_rf_wren, o_tx_data, o_tx_idx, o_tx_valid, o_tx_last, o_rx_ready};

  regfile_dump_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_mode      (i_mode),
    .i_first_idx (i_first_idx),
    .i_last_idx  (i_last_idx),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_csum_err  (o_csum_err),
    .o_rf_raddr  (o_rf_raddr),
    .i_rf_rdata  (i_rf_rdata),
    .o_rf_waddr  (o_rf_waddr),
    .o_rf_wdata  (o_rf_wdata),
    .o_rf_wren   (o_rf_wren),
    .o_tx_data   (o_tx_data),
    .o_tx_idx    (o_tx_idx),
    .o_tx_valid  (o_tx_valid),
    .o_tx_last   (o_tx_last),
    .i_tx_ready  (i_tx_ready),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_rx_ready  (o_rx_ready)
  );

  // All tasks start and end just after a falling edge.
  task automatic poke(input int idx, input logic [XLEN-1:0] val);
    tb_we = 1'b1;
    tb_waddr = AW'(idx);
    tb_wdata = val;
    @(negedge i_clk);
    tb_we = 1'b0;
    rf_exp[idx] = val;
  endtask

  function automatic int beats(input int first, input int last);
    return ((last - first + NR) % NR) + 1;
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL reset_held outs=%h exp=0", all_outs);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL reset_release outs=%h exp=0", all_outs);
    end
  endtask

  task automatic init_rf();
    poke(0, '0);
    for (int i = 1; i < NR; i++) poke(i, $urandom);
  endtask

  // rmode: 0 ready always high, 1 ready alternates per valid cycle, 2 random.
  // poke_at >= 0 raises a conflicting i_start on that cycle of the transfer.
  task automatic do_dump(input int first, input int last, input int rmode, input int poke_at);
    int n, tot, k, last_hs;
    bit finished, rdy, tog;
    logic [XLEN-1:0] csum, exp_d;
    logic [AW-1:0] exp_i;
    logic exp_l;
    n = beats(first, last);
    tot = n;
`ifdef REGFILE_DUMP_CSUM_EN
    tot = n + 1;
`endif
    csum = '0;
    for (int j = 0; j < n; j++) csum ^= rf_exp[(first + j) % NR];
    i_start = 1'b1;
    i_mode = 1'b0;
    i_first_idx = AW'(first);
    i_last_idx = AW'(last);
    @(negedge i_clk);
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL dump_busy got=%b exp=1", o_busy);
    end
    k = 0;
    last_hs = -10;
    finished = 0;
    tog = 1;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (o_done) begin
        checks++;
        if (k != tot || cyc != last_hs + 1) begin
          failures++;
          $display("FAIL dump_done beats=%0d exp=%0d cyc=%0d exp_cyc=%0d", k, tot, cyc,
                   last_hs + 1);
        end
        finished = 1;
      end else if (o_tx_valid) begin
        if (k < n) begin
          exp_i = AW'((first + k) % NR);
          exp_d = rf_exp[(first + k) % NR];
`ifdef REGFILE_DUMP_CSUM_EN
          exp_l = 1'b0;
`else
          exp_l = (k == n - 1);
`endif
        end else begin
          exp_i = '0;
          exp_d = csum;
          exp_l = 1'b1;
        end
        checks++;
        if (k >= tot || o_tx_data !== exp_d || o_tx_idx !== exp_i || o_tx_last !== exp_l) begin
          failures++;
          $display("FAIL dump_beat%0d got=(%0d,%h,%b) exp=(%0d,%h,%b)", k, o_tx_idx, o_tx_data,
                   o_tx_last, exp_i, exp_d, exp_l);
        end
        case (rmode)
          0: rdy = 1;
          1: begin rdy = tog; tog = ~tog; end
          default: rdy = 1'($urandom);
        endcase
        i_tx_ready = rdy;
        if (rdy) begin
          k++;
          last_hs = cyc;
        end
      end else begin
        i_tx_ready = 1'($urandom);
      end
      if (cyc == poke_at) begin
        i_start = 1'b1;
        i_mode = 1'b1;
        i_first_idx = AW'($urandom);
        i_last_idx = AW'($urandom);
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
    end
    i_start = 1'b0;
    i_tx_ready = 1'b0;
    if (!finished) begin
      checks++;
      failures++;
      $display("FAIL dump_timeout beats=%0d exp=%0d", k, tot);
    end
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL dump_idle done=%b busy=%b exp=0,0", o_done, o_busy);
    end
  endtask

  // vmode: 0 valid always high, 1 random valid. Data comes from ld_data[].
  task automatic do_load(input int first, input int last, input int vmode,
                         input logic [XLEN-1:0] csum_val);
    int n, tot, k, last_hs, idx;
    bit finished, v, exp_we;
    logic [XLEN-1:0] x;
    logic exp_err;
    n = beats(first, last);
    tot = n;
    x = '0;
    for (int j = 0; j < n; j++) x ^= ld_data[j];
    exp_err = 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
    tot = n + 1;
    exp_err = (csum_val != x);
`endif
    i_start = 1'b1;
    i_mode = 1'b1;
    i_first_idx = AW'(first);
    i_last_idx = AW'(last);
    @(negedge i_clk);
    i_start = 1'b0;
    k = 0;
    last_hs = -10;
    finished = 0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (o_done) begin
        checks++;
        if (k != tot || cyc != last_hs + 1) begin
          failures++;
          $display("FAIL load_done beats=%0d exp=%0d cyc=%0d exp_cyc=%0d", k, tot, cyc,
                   last_hs + 1);
        end
        finished = 1;
      end else begin
        v = (vmode == 0) ? 1'b1 : 1'($urandom);
        i_rx_valid = v;
        i_rx_data = (k < n) ? ld_data[k] : ((k < tot) ? csum_val : $urandom);
        #1;
        if (o_rx_ready && v) begin
          checks++;
          if (k < n) begin
            idx = (first + k) % NR;
            exp_we = (idx != 0);
            if (o_rf_wren !== exp_we ||
                (exp_we && (o_rf_waddr !== AW'(idx) || o_rf_wdata !== ld_data[k]))) begin
              failures++;
              $display("FAIL load_beat%0d got=(%b,%0d,%h) exp=(%b,%0d,%h)", k, o_rf_wren,
                       o_rf_waddr, o_rf_wdata, exp_we, idx, ld_data[k]);
            end
            if (exp_we) rf_exp[idx] = ld_data[k];
          end else if (k >= tot || o_rf_wren !== 1'b0) begin
            failures++;
            $display("FAIL load_extra_beat%0d wren=%b exp=0", k, o_rf_wren);
          end
          k++;
          last_hs = cyc;
        end else if (o_rf_wren !== 1'b0) begin
          checks++;
          failures++;
          $display("FAIL load_idle_wren got=%b exp=0", o_rf_wren);
        end
      end
      @(negedge i_clk);
    end
    i_rx_valid = 1'b0;
    if (!finished) begin
      checks++;
      failures++;
      $display("FAIL load_timeout beats=%0d exp=%0d", k, tot);
    end
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (rf[i] !== rf_exp[i]) begin
        failures++;
        $display("FAIL load_rf x%0d got=%h exp=%h", i, rf[i], rf_exp[i]);
      end
    end
    checks++;
    if (o_csum_err !== exp_err || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL load_csum_err got=%b busy=%b exp=%b,0", o_csum_err, o_busy, exp_err);
    end
  endtask

  function automatic logic [XLEN-1:0] ld_xor(input int n);
    logic [XLEN-1:0] x;
    x = '0;
    for (int j = 0; j < n; j++) x ^= ld_data[j];
    return x;
  endfunction

  task automatic test_dump_basic();
    poke(5, 32'hDEADBEEF);
    poke(6, 32'h12345678);
    do_dump(5, 6, 0, -1);
  endtask

  task automatic test_dump_wrap();
    do_dump(30, 1, 1, -1);
  endtask

  task automatic test_load_x0();
    ld_data[0] = 32'hAAAA0000;
    ld_data[1] = 32'h11;
    ld_data[2] = 32'h22;
    do_load(0, 2, 0, ld_xor(3));
  endtask

  task automatic test_start_ignored();
    do_dump(10, 13, 0, 3);
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_dump(8, 11, 2, -1);
    i_tx_ready = 1'b0;
    i_start = 1'b1;
    i_mode = 1'b0;
    i_first_idx = AW'(8);
    i_last_idx = AW'(11);
    @(negedge i_clk);
    i_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (o_tx_valid) seen = 1;
      else @(negedge i_clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_mid_tx_valid got=0 exp=1");
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL reset_mid_dump outs=%h exp=0", all_outs);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    do_dump(8, 11, 0, -1);
    // Abort a load with a beat pending: the write must not land.
    i_start = 1'b1;
    i_mode = 1'b1;
    i_first_idx = AW'(3);
    i_last_idx = AW'(6);
    @(negedge i_clk);
    i_start = 1'b0;
    i_rx_valid = 1'b1;
    i_rx_data = 32'hC0FFEE01;
    @(negedge i_clk);
    rf_exp[3] = 32'hC0FFEE01;
    i_rx_data = 32'hC0FFEE02;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL reset_mid_load outs=%h exp=0", all_outs);
    end
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (rf[3] !== rf_exp[3] || rf[4] !== rf_exp[4]) begin
      failures++;
      $display("FAIL reset_mid_load_rf x3=%h x4=%h exp=%h,%h", rf[3], rf[4], rf_exp[3], rf_exp[4]);
    end
  endtask

`ifdef REGFILE_DUMP_CSUM_EN
  task automatic test_csum();
    ld_data[0] = 32'd3;
    ld_data[1] = 32'd5;
    do_load(1, 2, 0, 32'd7);
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_csum_err !== 1'b1) begin
      failures++;
      $display("FAIL csum_sticky got=%b exp=1", o_csum_err);
    end
    ld_data[0] = 32'd9;
    do_load(4, 4, 1, 32'd9);
  endtask
`endif

  task automatic test_random();
    int f, l, n;
    for (int t = 0; t < 6; t++) begin
      f = $urandom_range(0, NR - 1);
      l = $urandom_range(0, NR - 1);
      do_dump(f, l, 2, -1);
      f = $urandom_range(0, NR - 1);
      l = $urandom_range(0, NR - 1);
      n = beats(f, l);
      for (int j = 0; j < n; j++) ld_data[j] = $urandom;
      do_load(f, l, 1, ld_xor(n) ^ ((t % 3 == 0) ? 32'h1 : 32'h0));
    end
  endtask

  initial begin
    test_reset();
    init_rf();
    test_dump_basic();
    test_dump_wrap();
    test_load_x0();
    test_start_ignored();
    test_reset_mid();
`ifdef REGFILE_DUMP_CSUM_EN
    test_csum();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
